flicker_pwm_monitor: RTL and testbench

- Receive-side companion to the candle-flicker LED driver: samples the LED PWM output, measures each PWM period and its high time, and reports them per period.
- Used on the bench and on-chip as a self-check of the flicker generator; detects a stuck LED line.
- Sits directly on the LED output net (io_out[0]); results go to debug outputs or a scan register.

---
 rtl/flicker_pwm_monitor.sv | 127 ++++++++++++
 tb/tb_flicker_pwm_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/flicker_pwm_monitor.sv
// Measures period and high time of the flicker LED PWM line.
// Flags a stuck line when no rising edge arrives within the counter range.
module flicker_pwm_monitor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic             level,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             stuck_level_q, stuck_level_d;
  logic             rise;

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    sync1_d       = pwm_in;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    state_d       = state_q;
    per_cnt_d     = per_cnt_q;
    hi_cnt_d      = hi_cnt_q;
    period_d      = period_q;
    high_time_d   = high_time_q;
    valid_d       = 1'b0;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;
    case (state_q)
      IDLE: begin
        per_cnt_d = '0;
        hi_cnt_d  = '0;
        if (rise) begin
          state_d   = MEASURE;
          per_cnt_d = CNT_ONE;
          hi_cnt_d  = CNT_ONE;
          stuck_d   = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d    = per_cnt_q;
          high_time_d = hi_cnt_q;
          valid_d     = 1'b1;
          per_cnt_d   = CNT_ONE;
          hi_cnt_d    = CNT_ONE;
          stuck_d     = 1'b0;
        end else if (per_cnt_q == CNT_MAX) begin
          // Range exhausted without an edge: report a zero result.
          state_d       = IDLE;
          stuck_d       = 1'b1;
          stuck_level_d = sync2_q;
          period_d      = '0;
          high_time_d   = '0;
          valid_d       = 1'b1;
          per_cnt_d     = '0;
          hi_cnt_d      = '0;
        end else begin
          per_cnt_d = per_cnt_q + CNT_ONE;
          if (sync2_q && (hi_cnt_q != CNT_MAX)) begin
            hi_cnt_d = hi_cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      prev_q        <= 1'b0;
      per_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      period_q      <= '0;
      high_time_q   <= '0;
      valid_q       <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      per_cnt_q     <= per_cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      period_q      <= period_d;
      high_time_q   <= high_time_d;
      valid_q       <= valid_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign level       = sync2_q;
  assign period      = period_q;
  assign high_time   = high_time_q;
  assign valid       = valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_flicker_pwm_monitor.sv
// Scoreboard bench for flicker_pwm_monitor (CNT_W=8).
// Expected reports are queued at each driven rise and checked on valid.
module tb_flicker_pwm_monitor;

  localparam int W = 8;

  typedef struct {
    int p;
    int h;
    int s;
    int sl;
    int cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         pwm_in = 1'b0;
  logic         level;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         stuck;
  logic         stuck_level;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rise = 0;
  logic prev_v = 1'b0;
  exp_t q[$];

  flicker_pwm_monitor #(.CNT_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .pwm_in(pwm_in),
    .level(level),
    .period(period),
    .high_time(high_time),
    .valid(valid),
    .stuck(stuck),
    .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(int p, int h, int s, int sl, int c);
    exp_t e;
    e.p = p;
    e.h = h;
    e.s = s;
    e.sl = sl;
    e.cyc = c;
    q.push_back(e);
  endtask

  // One input period: high for h cycles, low for p-h cycles.
  task automatic drive_period(int p, int h, bit do_push,
                              int ep, int eh, int esl);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      pwm_in = (i < h);
      if (i == 0) begin
        last_rise = cyc;
        if (do_push) push(ep, eh, 0, esl, cyc + 3);
      end
    end
  endtask

  // Monitor: pops and compares whenever the DUT strobes valid.
  always @(negedge clk) begin
    exp_t e;
    if (rst && valid) begin
      chk("back_to_back_valid", int'(prev_v), 0);
      chk("ht_le_period", int'(high_time <= period), 1);
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("period", int'(period), e.p);
        chk("high_time", int'(high_time), e.h);
        chk("stuck", int'(stuck), e.s);
        chk("stuck_level", int'(stuck_level), e.sl);
        chk("valid_cycle", cyc, e.cyc);
      end
    end
    prev_v = rst && valid;
  end

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_high_time"}, int'(high_time), 0);
    chk({tag, "_stuck"}, int'(stuck), 0);
    chk({tag, "_stuck_level"}, int'(stuck_level), 0);
    chk({tag, "_level"}, int'(level), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 10/3 train, first rise reports nothing
    drive_period(10, 3, 1'b0, 0, 0, 0);
    repeat (4) drive_period(10, 3, 1'b1, 10, 3, 0);
    chk("stuck_train", int'(stuck), 0);

    // change to 7/6
    drive_period(7, 6, 1'b1, 10, 3, 0);
    repeat (2) drive_period(7, 6, 1'b1, 7, 6, 0);

    // fastest input: period 2, high 1
    drive_period(2, 1, 1'b1, 7, 6, 0);
    repeat (3) drive_period(2, 1, 1'b1, 2, 1, 0);

    // line stuck high after a rise
    @(negedge clk);
    pwm_in = 1'b1;
    last_rise = cyc;
    push(2, 1, 0, 0, cyc + 3);
    push(0, 0, 1, 1, cyc + 258);
    repeat (299) @(negedge clk);
    chk("stuck_hi", int'(stuck), 1);
    chk("stuck_hi_level", int'(stuck_level), 1);
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("stuck_hold", int'(stuck), 1);
    drive_period(10, 3, 1'b0, 0, 0, 0);
    chk("stuck_cleared", int'(stuck), 0);
    drive_period(10, 3, 1'b1, 10, 3, 1);

    // line stuck low
    push(0, 0, 1, 0, last_rise + 258);
    repeat (290) @(negedge clk);
    chk("stuck_lo", int'(stuck), 1);
    chk("stuck_lo_level", int'(stuck_level), 0);

    // reset mid-period
    drive_period(10, 3, 1'b0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pwm_in = (i < 3);
      if (i == 0) push(10, 3, 0, 0, cyc + 3);
    end
    #1 rst = 1'b0;
    #1 chk_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    drive_period(10, 3, 1'b0, 0, 0, 0);
    drive_period(10, 3, 1'b1, 10, 3, 0);
    drive_period(10, 3, 1'b1, 10, 3, 0);
    @(negedge clk);
    pwm_in = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
